// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter (rev 1.0): shares one single-port memory between instruction fetch
// and load/store, data-first with a bounded data streak and a hung-memory timeout.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                owner,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          streak_q;
  logic [7:0]          tmo_q;
  logic                if_ack_q;
  logic                d_ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                owner_q;

  logic grant_d_d;
  logic grant_if_d;
  logic tmo_hit_d;

  // Data wins unless it has already taken MAX_D_STREAK grants in a row over a waiting fetch.
  assign grant_d_d  = d_req && (!if_req || (streak_q < 4'(MAX_D_STREAK)));
  assign grant_if_d = !grant_d_d && if_req;
  assign tmo_hit_d  = (TIMEOUT != 0) && (({1'b0, tmo_q} + 9'd1) == 9'(TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_d_d || grant_if_d) begin
            mem_req_q <= 1'b1;
            owner_q   <= grant_d_d;
            tmo_q     <= '0;
            state_q   <= S_BUSY;
            if (grant_d_d) begin
              mem_we_q    <= d_we;
              mem_be_q    <= d_be;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              if (!if_req) begin
                streak_q <= '0;
              end else if (streak_q < 4'(MAX_D_STREAK)) begin
                streak_q <= streak_q + 4'd1;
              end
            end else begin
              mem_we_q    <= 1'b0;
              mem_be_q    <= '0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              streak_q    <= '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack || tmo_hit_d) begin
            mem_req_q <= 1'b0;
            err_q     <= !mem_ack;
            state_q   <= S_RESP;
            if (owner_q) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= mem_ack ? mem_rdata : '0;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_RESP: begin
          // Requests are ignored here so the requester can drop req after its ack.
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: randomized and directed self-checking bench for mem_port_arbiter
// against a behavioural memory/arbitration model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clock, reset;
  logic        if_req, if_ack, d_req, d_we, d_ack, err;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_req, mem_we, mem_ack, owner, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks, errors;
  int mem_lat;
  bit mem_hang, stray_ack;

  logic [31:0] sim_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [15:0] cycles;
    logic [15:0] req_cycles;
    logic [31:0] m_addr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        unstable;
    logic        wrong_ack;
    logic        got_ack;
    logic        ack_long;
  } res_t;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sim_rd(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory: acks mem_lat cycles after it first sees mem_req, never when hung.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        stray_ack = 1'b0;
      end else if (mem_req && !mem_hang) begin
        if (wait_cnt < mem_lat) begin
          wait_cnt++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = sim_rd(mem_addr);
          if (mem_we) sim_mem[mem_addr] = merge(sim_rd(mem_addr), mem_wdata, mem_be);
        end
      end else if (!mem_req) begin
        wait_cnt = 0;
      end
    end
  end

  // Drives one request from IDLE and records what the DUT did; entered and left #1 after a rising edge.
  task automatic run_txn(input bit is_d, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, output res_t r);
    bit seen;
    r = '0;
    seen = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 0; n < 300 && !r.got_ack; n++) begin
      @(posedge clock); #1;
      r.cycles = r.cycles + 16'd1;
      if (mem_req) begin
        r.req_cycles = r.req_cycles + 16'd1;
        if (!seen) begin
          seen = 1'b1;
          r.m_addr = mem_addr; r.m_we = mem_we; r.m_be = mem_be; r.m_wdata = mem_wdata;
        end else if ({mem_addr, mem_we, mem_be, mem_wdata} !== {r.m_addr, r.m_we, r.m_be, r.m_wdata}) begin
          r.unstable = 1'b1;
        end
      end
      if (is_d ? if_ack : d_ack) r.wrong_ack = 1'b1;
      if (is_d ? d_ack : if_ack) begin
        r.got_ack = 1'b1;
        r.rdata   = is_d ? d_rdata : if_rdata;
        r.err     = err;
      end
    end
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    @(posedge clock); #1;
    r.ack_long = is_d ? d_ack : if_ack;
  endtask

  task automatic test_reset();
    bit bad;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({if_ack, d_ack, err, mem_req, mem_we, owner, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 0000000", {if_ack, d_ack, err, mem_req, mem_we, owner, busy});
    end
    checks++;
    if ({mem_be, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: got addr %h wdata %h be %h if_rd %h d_rd %h exp all 0",
                         mem_addr, mem_wdata, mem_be, if_rdata, d_rdata);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    stray_ack = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      if (if_ack || d_ack || busy || mem_req) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL stray_mem_ack: activity %b if_rd %h d_rd %h exp 0 0 0", bad, if_rdata, d_rdata);
    end
  endtask

  task automatic test_single_fetch();
    res_t r;
    sim_mem[32'h10] = 32'h13;
    mem_lat = 1;
    run_txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, r);
    checks++;
    if (r.got_ack !== 1'b1 || r.rdata !== 32'h13 || r.err !== 1'b0) begin
      errors++; $display("FAIL fetch_data: ack %b rdata %h err %b exp 1 00000013 0", r.got_ack, r.rdata, r.err);
    end
    checks++;
    if (r.m_addr !== 32'h10 || r.m_we !== 1'b0) begin
      errors++; $display("FAIL fetch_mem: addr %h we %b exp 00000010 0", r.m_addr, r.m_we);
    end
    checks++;
    if (r.cycles !== 16'd3 || r.wrong_ack !== 1'b0 || r.ack_long !== 1'b0) begin
      errors++; $display("FAIL fetch_timing: cycles %0d d_ack %b long %b exp 3 0 0", r.cycles, r.wrong_ack, r.ack_long);
    end
  endtask

  task automatic test_store();
    res_t r;
    mem_lat = 3;
    run_txn(1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, r);
    ref_mem[32'h200] = merge(ref_rd(32'h200), 32'hDEAD_BEEF, 4'b0011);
    checks++;
    if ({r.m_addr, r.m_we, r.m_be, r.m_wdata} !== {32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL store_mem: addr %h we %b be %b wdata %h exp 00000200 1 0011 deadbeef",
                         r.m_addr, r.m_we, r.m_be, r.m_wdata);
    end
    checks++;
    if (r.unstable !== 1'b0 || r.req_cycles !== 16'd4 || r.got_ack !== 1'b1 || r.ack_long !== 1'b0) begin
      errors++; $display("FAIL store_hold: unstable %b req_cycles %0d ack %b long %b exp 0 4 1 0",
                         r.unstable, r.req_cycles, r.got_ack, r.ack_long);
    end
    mem_lat = 0;
    run_txn(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, r);
    checks++;
    if (r.rdata !== ref_rd(32'h200) || r.cycles !== 16'd2) begin
      errors++; $display("FAIL store_readback: rdata %h cycles %0d exp %h 2", r.rdata, r.cycles, ref_rd(32'h200));
    end
  endtask

  task automatic test_concurrent();
    logic order [$];
    int   gt [$];
    int   d_t, f_t;
    logic [31:0] d_rd, f_rd;
    logic prev, g0, g1;
    int   gt1;
    mem_lat = 1;
    prev = 1'b0; d_t = -1; f_t = -1; d_rd = '0; f_rd = '0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100; d_wdata = '0;
    if_req = 1'b1; if_addr = 32'h40;
    for (int t = 1; t <= 60 && (d_t < 0 || f_t < 0); t++) begin
      @(posedge clock); #1;
      if (mem_req && !prev) begin order.push_back(owner); gt.push_back(t); end
      prev = mem_req;
      if (d_ack) begin d_t = t; d_rd = d_rdata; d_req = 1'b0; end
      if (if_ack) begin f_t = t; f_rd = if_rdata; if_req = 1'b0; end
    end
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clock); #1;
    g0  = (order.size() > 0) ? order[0] : 1'bx;
    g1  = (order.size() > 1) ? order[1] : 1'bx;
    gt1 = (gt.size() > 1) ? gt[1] : -1;
    checks++;
    if (order.size() != 2 || g0 !== 1'b1 || g1 !== 1'b0) begin
      errors++; $display("FAIL conc_order: grants %0d first %b second %b exp 2 1 0", order.size(), g0, g1);
    end
    checks++;
    if (d_t < 0 || gt1 != d_t + 2) begin
      errors++; $display("FAIL conc_fetch_slot: fetch grant at %0d exp %0d", gt1, d_t + 2);
    end
    checks++;
    if (d_rd !== ref_rd(32'h100) || f_rd !== ref_rd(32'h40)) begin
      errors++; $display("FAIL conc_data: d %h f %h exp %h %h", d_rd, f_rd, ref_rd(32'h100), ref_rd(32'h40));
    end
  endtask

  task automatic test_timeout();
    res_t r;
    mem_hang = 1'b1;
    run_txn(1'b0, 1'b0, 4'h0, 32'h80, 32'h0, r);
    mem_hang = 1'b0;
    checks++;
    if (r.got_ack !== 1'b1 || r.err !== 1'b1 || r.rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_resp: ack %b err %b rdata %h exp 1 1 00000000", r.got_ack, r.err, r.rdata);
    end
    checks++;
    if (r.req_cycles !== 16'(TMO) || r.cycles !== 16'(TMO + 1) || r.wrong_ack !== 1'b0) begin
      errors++; $display("FAIL tmo_timing: req_cycles %0d cycles %0d d_ack %b exp %0d %0d 0",
                         r.req_cycles, r.cycles, r.wrong_ack, TMO, TMO + 1);
    end
    mem_lat = 2;
    run_txn(1'b1, 1'b0, 4'hF, 32'h84, 32'h0, r);
    checks++;
    if (r.got_ack !== 1'b1 || r.err !== 1'b0 || r.rdata !== ref_rd(32'h84) || r.cycles !== 16'd4) begin
      errors++; $display("FAIL tmo_recover: ack %b err %b rdata %h cycles %0d exp 1 0 %h 4",
                         r.got_ack, r.err, r.rdata, r.cycles, ref_rd(32'h84));
    end
  endtask

  task automatic test_random();
    res_t r;
    int kind, lat;
    logic [31:0] addr, wdata, exp;
    logic [3:0] be;
    for (int i = 0; i < 30; i++) begin
      kind  = $urandom_range(0, 2);
      lat   = $urandom_range(0, 3);
      addr  = 32'h300 + 32'(4 * $urandom_range(0, 3));
      wdata = $urandom;
      be    = 4'($urandom);
      mem_lat = lat;
      exp = ref_rd(addr);
      run_txn(kind != 0, kind == 2, be, addr, wdata, r);
      if (kind == 2) ref_mem[addr] = merge(ref_rd(addr), wdata, be);
      checks++;
      if (r.got_ack !== 1'b1 || r.err !== 1'b0 || r.wrong_ack !== 1'b0 || r.ack_long !== 1'b0) begin
        errors++; $display("FAIL rnd_ack[%0d]: ack %b err %b other %b long %b exp 1 0 0 0",
                           i, r.got_ack, r.err, r.wrong_ack, r.ack_long);
      end
      checks++;
      if (r.cycles !== 16'(lat + 2) || r.req_cycles !== 16'(lat + 1) || r.unstable !== 1'b0) begin
        errors++; $display("FAIL rnd_timing[%0d]: cycles %0d req %0d unstable %b exp %0d %0d 0",
                           i, r.cycles, r.req_cycles, r.unstable, lat + 2, lat + 1);
      end
      checks++;
      if (r.m_addr !== addr || r.m_we !== (kind == 2)) begin
        errors++; $display("FAIL rnd_mem[%0d]: addr %h we %b exp %h %b", i, r.m_addr, r.m_we, addr, kind == 2);
      end
      if (kind == 2) begin
        checks++;
        if (r.m_be !== be || r.m_wdata !== wdata) begin
          errors++; $display("FAIL rnd_store[%0d]: be %b wdata %h exp %b %h", i, r.m_be, r.m_wdata, be, wdata);
        end
      end else begin
        checks++;
        if (r.rdata !== exp) begin
          errors++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", i, r.rdata, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    bit seen;
    int ackcnt;
    mem_lat = 0;
    if_req = 1'b1; if_addr = 32'h700;
    for (int k = 0; k < 2; k++) begin
      run_txn(1'b1, 1'b0, 4'hF, 32'h720 + 32'(4 * k), 32'h0, r);
      checks++;
      if (r.got_ack !== 1'b1 || r.wrong_ack !== 1'b0) begin
        errors++; $display("FAIL rmid_pre[%0d]: ack %b if_ack %b exp 1 0", k, r.got_ack, r.wrong_ack);
      end
    end
    mem_hang = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h728;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clock); #1;
      seen = mem_req && owner;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL rmid_grant: data grant seen %b exp 1", seen);
    end
    repeat (2) @(posedge clock);
    #4;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, owner} !== 3'b000) begin
      errors++; $display("FAIL rmid_async: mem_req/busy/owner %b exp 000", {mem_req, busy, owner});
    end
    d_req = 1'b0; if_req = 1'b0; mem_hang = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    ackcnt = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (if_ack || d_ack || mem_req) ackcnt++;
    end
    checks++;
    if (ackcnt != 0) begin
      errors++; $display("FAIL rmid_no_ack: activity cycles %0d exp 0", ackcnt);
    end
  endtask

  // Both sides keep requesting: expected order follows the streak rule from a zero streak.
  task automatic test_streak();
    logic g [$];
    logic exp_o, got_o;
    mem_lat = 0;
    fork
      begin : data_side
        for (int k = 0; k < 8; k++) begin
          bit got;
          got = 1'b0;
          d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500 + 32'(4 * k);
          for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clock); #1;
            got = d_ack;
          end
          d_req = 1'b0;
          if (!got) begin
            checks++; errors++; $display("FAIL streak_d_wait[%0d]: d_ack 0 exp 1", k);
          end
          @(posedge clock); #1;
        end
      end
      begin : fetch_side
        for (int k = 0; k < 2; k++) begin
          bit got;
          got = 1'b0;
          if_req = 1'b1; if_addr = 32'h600 + 32'(4 * k);
          for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clock); #1;
            got = if_ack;
          end
          if_req = 1'b0;
          if (!got) begin
            checks++; errors++; $display("FAIL streak_f_wait[%0d]: if_ack 0 exp 1", k);
          end
          @(posedge clock); #1;
        end
      end
      begin : monitor
        logic prev;
        prev = 1'b0;
        for (int t = 0; t < 400 && g.size() < 10; t++) begin
          @(posedge clock); #1;
          if (mem_req && !prev) g.push_back(owner);
          prev = mem_req;
        end
      end
    join
    for (int i = 0; i < 10; i++) begin
      exp_o = ((i % (MAXS + 1)) == MAXS) ? 1'b0 : 1'b1;
      got_o = (i < g.size()) ? g[i] : 1'bx;
      checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL streak_order[%0d]: owner %b exp %b", i, got_o, exp_o);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_lat = 0; mem_hang = 1'b0; stray_ack = 1'b0;
    test_reset();
    test_single_fetch();
    test_store();
    test_concurrent();
    test_timeout();
    test_random();
    test_reset_mid();
    test_streak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the CPU instruction-fetch path and the load/store path.
- Sequences one memory transaction at a time using a req/ack handshake on each side.
- Data accesses have priority; a streak limit guarantees that fetch is not starved.
- Sits between the Datapath fetch and load/store units and the memory model; includes a timeout guard for hung memories.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_D_STREAK, 4, maximum consecutive data grants while if_req is pending. Range 1..15.
- TIMEOUT, 255, maximum BUSY cycles to wait for mem_ack. 0 disables the timeout. Range 0..255.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse: fetch transaction complete.
- if_rdata  out  DATA_W  fetch data; valid while if_ack is high.
- d_req  in  1  data request; held high with its fields stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse: data transaction complete.
- d_rdata  out  DATA_W  load data; valid while d_ack is high.
- err  out  1  valid only with an ack; 1 = transaction aborted by timeout.
- mem_req  out  1  memory request; held until mem_ack or timeout.
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered copy of the granted request.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; single-cycle pulse.
- owner  out  1  0 = fetch, 1 = data; the current or last grant.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset values: state IDLE; all outputs 0; streak counter and timeout counter 0.
- Reset mid-transaction: the in-flight access is abandoned immediately. mem_req drops asynchronously, and no ack is issued after release.
- State IDLE: arbitration on a rising edge.
  - d_req high and (if_req low or streak < MAX_D_STREAK) → grant data.
  - Otherwise if_req high → grant fetch.
  - Neither request → stay in IDLE.
  - On grant: latch the request fields into the mem_* registers, set mem_req=1, set owner, go to BUSY.
- Streak counter:
  - Data grant while if_req is high → increment, saturating at MAX_D_STREAK.
  - Data grant while if_req is low → clear to 0.
  - Fetch grant → clear to 0.
- State BUSY:
  - mem_* outputs are held stable.
  - On mem_ack: capture mem_rdata into the owner's rdata register, err=0, drop mem_req, go to RESP.
  - Timeout: when TIMEOUT≠0 and the counter reaches TIMEOUT with no mem_ack, set err=1, set rdata=0, drop mem_req, go to RESP.
  - The timeout counter clears on every grant.
- State RESP:
  - Exactly one cycle.
  - Assert the owner's ack with its rdata and err; the other ack stays 0.
  - Ignore all requests this cycle, so the requester has time to drop req.
  - Go to IDLE.
- Latency: request seen at edge N → mem_req high after edge N. mem_ack seen at edge M → ack high in cycle M+1. IDLE at M+2.
  - Minimum turnaround is 3 cycles with zero-wait memory.
- Simultaneous requests in IDLE: data wins, subject to the streak rule.
- A req that arrives while BUSY or in RESP waits; it is not lost, because requesters hold req.
- mem_ack outside BUSY is ignored.
- rdata registers hold their last value between acks. Rdata content is don't-care when ack is low.
- Stores: d_rdata returns whatever mem_rdata holds with mem_ack. Requesters ignore it.

Test Plan:
- Single fetch, if_addr=0x0000_0010, memory acks 2 cycles after mem_req with 0x0000_0013 → mem_addr=0x10, mem_we=0. if_ack pulses once with if_rdata=0x13 and err=0. d_ack stays 0.
- Concurrent requests: if_req and d_req (load at 0x100) raised in the same cycle → data granted first (owner=1). Fetch is granted in the IDLE that follows its RESP.
- Starvation guard, MAX_D_STREAK=4: d_req re-raised continuously and if_req held → grant order is D,D,D,D,F,D…
- Store: d_we=1, d_be=4'b0011, d_wdata=0xDEAD_BEEF, d_addr=0x200 → mem_* carry exactly these values, held stable until mem_ack. d_ack is one cycle.
- Timeout, TIMEOUT=8, mem_ack never asserted → mem_req drops after 8 BUSY cycles. Requester ack has err=1 and rdata=0. The next request proceeds normally.
- Reset asserted while BUSY → mem_req, busy and owner go to 0 without waiting for a clock edge. No ack after reset release. The streak counter restarts from 0.
